// File: rtl/idwt_if.sv
// Handshake bundle for the inverse Haar DWT: coefficient pairs in, serial samples out.
// The master side drives the coefficients and out_ready; the slave side is the idwt block.
interface idwt_if;
  logic signed [7:0] avg_in;
  logic signed [7:0] diff_in;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] sample_out;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        sat_count;
  logic              busy;

  modport master (
    output avg_in, diff_in, in_valid, out_ready,
    input  in_ready, sample_out, out_valid, sat_count, busy
  );

  modport slave (
    input  avg_in, diff_in, in_valid, out_ready,
    output in_ready, sample_out, out_valid, sat_count, busy
  );
endinterface

// File: rtl/idwt.sv
// Single-level inverse Haar DWT: buffers (avg, diff) pairs, emits saturated avg+diff
// then avg-diff, one sample per accepted output beat.
module idwt #(
  parameter int PAIR_DEPTH = 4
) (
  input logic   clk,
  input logic   rst_n,
  idwt_if.slave bus
);

  localparam int PTR_W = (PAIR_DEPTH > 1) ? $clog2(PAIR_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(PAIR_DEPTH);

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2
  } state_e;

  // Clamp a 9-bit signed result to 8 bits; MSB of the return flags a clamp.
  function automatic logic [8:0] sat_fn(input logic signed [8:0] v);
    logic [8:0] r;
    if (v > 9'sd127) begin
      r = {1'b1, 8'h7F};
    end else if (v < -9'sd128) begin
      r = {1'b1, 8'h80};
    end else begin
      r = {1'b0, v[7:0]};
    end
    return r;
  endfunction

  logic [15:0]      mem_q [PAIR_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, busy_q;

  state_e           state_q;
  logic [7:0]       sample_q, hold_q, sat_cnt_q, sat_cnt_d;
  logic             out_valid_q;

  logic             push_s, pop_s, stage_busy_s;
  logic [15:0]      head_s;
  logic signed [8:0] s1_wide_s, s2_wide_s;
  logic [8:0]       s1_sat_s, s2_sat_s;
  logic [1:0]       sat_inc_s;
  logic [8:0]       sat_sum_s;

  // Handshake decode, pair arithmetic and next occupancy.
  always_comb begin
    push_s = bus.in_valid && in_ready_q;
    case (state_q)
      ST_EMPTY:  pop_s = (count_q != {CNT_W{1'b0}});
      ST_SECOND: pop_s = bus.out_ready && (count_q != {CNT_W{1'b0}});
      default:   pop_s = 1'b0;
    endcase

    // The output stage stays occupied unless it is draining its second sample with nothing to refill.
    stage_busy_s = pop_s || (state_q == ST_FIRST) ||
                   ((state_q == ST_SECOND) && !bus.out_ready);

    head_s    = mem_q[rd_ptr_q];
    s1_wide_s = $signed({head_s[15], head_s[15:8]}) + $signed({head_s[7], head_s[7:0]});
    s2_wide_s = $signed({head_s[15], head_s[15:8]}) - $signed({head_s[7], head_s[7:0]});
    s1_sat_s  = sat_fn(s1_wide_s);
    s2_sat_s  = sat_fn(s2_wide_s);

    sat_inc_s = {1'b0, s1_sat_s[8]} + {1'b0, s2_sat_s[8]};
    sat_sum_s = {1'b0, sat_cnt_q} + {7'd0, sat_inc_s};
    if (sat_sum_s > 9'd255) begin
      sat_cnt_d = 8'd255;
    end else begin
      sat_cnt_d = sat_sum_s[7:0];
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pair FIFO storage, pointers, and the registered in_ready/busy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PAIR_DEPTH; i++) begin
        mem_q[i] <= 16'd0;
      end
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= {bus.avg_in, bus.diff_in};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q    <= count_d;
      in_ready_q <= (count_d != FULL_CNT);
      busy_q     <= (count_d != {CNT_W{1'b0}}) || stage_busy_s;
    end
  end

  // Output FSM: loads s1 to the output and s2 to the hold register on each pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      sample_q    <= 8'd0;
      hold_q      <= 8'd0;
      out_valid_q <= 1'b0;
      sat_cnt_q   <= 8'd0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (pop_s) begin
            state_q     <= ST_FIRST;
            sample_q    <= s1_sat_s[7:0];
            hold_q      <= s2_sat_s[7:0];
            out_valid_q <= 1'b1;
            sat_cnt_q   <= sat_cnt_d;
          end
        end
        ST_FIRST: begin
          if (bus.out_ready) begin
            state_q  <= ST_SECOND;
            sample_q <= hold_q;
          end
        end
        ST_SECOND: begin
          if (bus.out_ready) begin
            if (pop_s) begin
              state_q     <= ST_FIRST;
              sample_q    <= s1_sat_s[7:0];
              hold_q      <= s2_sat_s[7:0];
              out_valid_q <= 1'b1;
              sat_cnt_q   <= sat_cnt_d;
            end else begin
              state_q     <= ST_EMPTY;
              out_valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.sample_out = sample_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.sat_count  = sat_cnt_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_idwt.sv
// Scoreboard bench for idwt: stimulus pushes expected samples, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_idwt;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  idwt_if bus();

  idwt #(.PAIR_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int first_beat = 0;
  int last_beat = 0;
  logic signed [7:0] exp_q[$];
  logic prev_hold = 1'b0;
  logic signed [7:0] prev_sample = 8'sd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [7:0] sat8(input int v);
    if (v > 127) return 8'sd127;
    else if (v < -128) return -8'sd128;
    else return 8'(v);
  endfunction

  // Monitor: scoreboard compare on every accepted beat, plus hold-stability check.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", int'(bus.out_valid), 1);
        chk("hold_sample", int'(bus.sample_out), int'(prev_sample));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sample: got %0d, expected no output", bus.sample_out);
        end else begin
          chk("sample", int'(bus.sample_out), int'(exp_q.pop_front()));
        end
        beats++;
        if (beats == 1) first_beat = cyc;
        last_beat = cyc;
      end
      prev_hold   = bus.out_valid && !bus.out_ready;
      prev_sample = bus.sample_out;
    end
  end

  task automatic send(input logic signed [7:0] a, input logic signed [7:0] d,
                      input logic signed [7:0] e1, input logic signed [7:0] e2);
    int n;
    logic acc;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    bus.avg_in   = a;
    bus.diff_in  = d;
    bus.in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      if (bus.in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    chk("pair_accepted", int'(acc), 1);
  endtask

  task automatic drain();
    int n;
    bus.in_valid = 1'b0;
    n = 0;
    while ((bus.busy || exp_q.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_queue_empty", exp_q.size(), 0);
    chk("drain_busy", int'(bus.busy), 0);
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_sample", int'(bus.sample_out), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_sat_count", int'(bus.sat_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.avg_in = 8'sd0;
    bus.diff_in = 8'sd0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk_reset_state();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic pair and the three saturation cases.
    send(8'sd10, 8'sd3, 8'sd13, 8'sd7);
    drain();
    chk("sat_basic", int'(bus.sat_count), 0);
    send(8'sd100, 8'sd50, 8'sd127, 8'sd50);
    drain();
    chk("sat_after_1", int'(bus.sat_count), 1);
    send(-8'sd100, 8'sd50, -8'sd50, -8'sd128);
    drain();
    chk("sat_after_2", int'(bus.sat_count), 2);
    send(-8'sd128, -8'sd128, -8'sd128, 8'sd0);
    drain();
    chk("sat_after_3", int'(bus.sat_count), 3);

    // Backpressure: five pairs fit, the sixth waits until the output drains.
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send(8'(i), 8'(i), 8'(2 * i), 8'sd0);
    end
    chk("full_in_ready", int'(bus.in_ready), 0);
    fork
      send(8'sd6, 8'sd6, 8'sd12, 8'sd0);
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("full_in_ready_held", int'(bus.in_ready), 0);
        chk("full_sample_hold", int'(bus.sample_out), 2);
        chk("full_out_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Streaming: 16 back-to-back pairs must produce 32 gapless beats.
    beats = 0;
    for (int k = 1; k <= 16; k++) begin
      send(8'(4 * k), 8'(k), 8'(5 * k), 8'(3 * k));
    end
    drain();
    chk("stream_beats", beats, 32);
    chk("stream_span", last_beat - first_beat, 31);

    // Random out_ready against the reference saturating model.
    begin
      logic done;
      done = 1'b0;
      fork
        begin
          for (int k = 0; k < 8; k++) begin
            int a, d;
            a = 30 * k - 100;
            d = 25 * k - 90;
            send(8'(a), 8'(d), sat8(a + d), sat8(a - d));
          end
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
          end
        end
      join
      bus.out_ready = 1'b1;
      drain();
    end

    // Reset between FIRST and SECOND with three pairs queued.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'sd20, 8'sd1, 8'sd21, 8'sd19);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_valid", int'(bus.out_valid), 1);
    chk("pre_rst_busy", int'(bus.busy), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk_reset_state();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(8'sd5, -8'sd2, 8'sd3, 8'sd7);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/idwt.md
# idwt

Single-level inverse Haar DWT for the EEG compression decoder path. Accepts signed 8-bit (average, difference) coefficient pairs over a valid/ready handshake, reconstructs the two time-domain samples per pair, and emits them serially, one sample per accepted output beat. It sits downstream of the RLE decoder and reverses the forward `dwt` block: the forward block takes sample pairs `(x1, x2)` and produces `average`/`difference`.

## Interface
- `PAIR_DEPTH`, 4, depth of the input pair FIFO (power of two, ≥2)
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `avg_in`  in  8  signed average coefficient
- `diff_in`  in  8  signed difference coefficient
- `in_valid`  in  1  coefficient pair present
- `in_ready`  out  1  block can accept a pair this cycle
- `sample_out`  out  8  signed reconstructed sample
- `out_valid`  out  1  `sample_out` valid
- `out_ready`  in  1  downstream accepts `sample_out`
- `sat_count`  out  8  count of saturated output samples, sticks at 255
- `busy`  out  1  FIFO non-empty or output stage occupied

## Operation
- Input transfer: a pair is accepted on a rising edge with `in_valid && in_ready`.
- `in_ready = !fifo_full`, which is purely registered state.
- FIFO: `PAIR_DEPTH` entries of `{avg, diff}`, with binary read/write pointers that wrap modulo `PAIR_DEPTH`. A push and a pop on the same edge are both honored and leave the occupancy count unchanged.
- Arithmetic, both computed at 9 bits signed (sign-extend the operands):
  - `s1 = avg + diff`
  - `s2 = avg - diff`
- Saturation: each result is saturated to [-128, 127] before it is stored. Every saturated sample increments `sat_count` when it is loaded, and `sat_count` holds at 255.
- FSM states:
  - EMPTY: `out_valid` = 0.
  - FIRST: `sample_out = s1`, `out_valid` = 1.
  - SECOND: `sample_out = s2`, `out_valid` = 1.
- Transitions:
  - EMPTY → FIRST when the FIFO is non-empty. This pops one pair, computes `s1`/`s2`, and registers `s1` to the output and `s2` to a hold register.
  - FIRST → SECOND on `out_ready`.
  - SECOND → FIRST on `out_ready` if the FIFO is non-empty (pops the next pair on the same edge).
  - SECOND → EMPTY on `out_ready` if the FIFO is empty.
  - Without `out_ready`, the state and `sample_out` hold.
- Output stability: `sample_out` and `out_valid` never change while `out_valid && !out_ready`.
- `busy = (fifo_count != 0) || (state != EMPTY)`.
- Reset (asynchronous, any time, including mid-pair):
  - FIFO pointers and count → 0.
  - State → EMPTY.
  - `sample_out` = 0, `out_valid` = 0, `in_ready` = 1, `sat_count` = 0, `busy` = 0.
  - Any partially emitted pair is discarded.

## Timing
- All outputs are registered. There is no combinational path from `in_valid` or `out_ready` to any output.
- Latency: for a pair accepted on edge E0 into an empty block, `s1` is valid after E1 and `s2` is valid after the first `out_ready` edge following E1.
- Throughput: with `out_ready` held high and the FIFO non-empty, the block emits one sample per cycle, i.e. one pair per 2 cycles with no bubbles.
- Input backpressure: `in_ready` deasserts the cycle after the FIFO reaches `PAIR_DEPTH` entries. Total buffering is `PAIR_DEPTH` + 1 pairs (one in the output stage).
- `sat_count` updates on the same edge that loads the pair into the output stage. A pair with two saturated samples adds 2.

## Test plan
- Basic: pair (10, 3) with `out_ready`=1 → `sample_out` 13 then 7 on consecutive cycles; `sat_count` stays 0.
- Saturation:
  - (100, 50) → 127 and 50, `sat_count` = 1.
  - (-100, 50) → -50 and -128, `sat_count` = 2.
  - (-128, -128) → -128 and 0, `sat_count` = 3.
- Backpressure and full: hold `out_ready`=0 and offer 6 pairs (1,1) … (6,6).
  - 5 pairs are accepted; `in_ready` goes low after the 5th accepted pair.
  - `sample_out` holds at 2.
  - Release `out_ready` → output sequence 2,0,4,0,6,0,8,0,10,0, and the 6th pair is then accepted.
- Streaming: 16 back-to-back pairs with `in_valid`=`out_ready`=1 → 32 samples in 32 consecutive cycles, no gaps, order preserved across FIFO pointer wrap.
- Random `out_ready` toggling → `sample_out` is stable whenever `out_valid && !out_ready`, and the sample stream matches the reference model.
- Reset mid-operation: assert `rst_n`=0 between the FIRST and SECOND samples with 3 pairs queued.
  - Immediately: `out_valid`=0, `sample_out`=0, `in_ready`=1, `busy`=0, `sat_count`=0.
  - After release, a new pair (5, -2) yields 3 then 7.
